// File: rtl/cpu_defines_pkg.sv
// cpu_defines_pkg: mul/div op and FSM state types shared by the EXE mul/div engine
package cpu_defines_pkg;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } MulDivOpType;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} MulDivStateType;
  function automatic logic op_is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative restoring divider, one quotient bit per cycle on magnitudes,
// signs restored on output; the first iteration is folded into the start cycle.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] r_q, q_q, d_q, r_in, q_in, d_in, r_nx, q_nx;
  logic [WIDTH:0] sh, df;
  logic [CW-1:0] cnt_q;
  logic busy_q, valid_q, negq_q, negr_q;
  always_comb begin
    r_in = start ? '0 : r_q;
    q_in = start ? ((sgn & a[WIDTH-1]) ? -a : a) : q_q;
    d_in = start ? ((sgn & b[WIDTH-1]) ? -b : b) : d_q;
    sh   = {r_in, q_in[WIDTH-1]};
    df   = sh - {1'b0, d_in};
    r_nx = df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0];
    q_nx = {q_in[WIDTH-2:0], !df[WIDTH]};
  end
  // a zero divisor keeps the all-ones quotient unsigned-looking; remainder sign follows a
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else if (abort) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (start) begin
      r_q     <= r_nx;
      q_q     <= q_nx;
      d_q     <= d_in;
      cnt_q   <= CW'(WIDTH - 1);
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      negq_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
      negr_q  <= sgn & a[WIDTH-1];
    end else if (busy_q) begin
      r_q     <= r_nx;
      q_q     <= q_nx;
      cnt_q   <= cnt_q - CW'(1);
      busy_q  <= cnt_q != CW'(1);
      valid_q <= cnt_q == CW'(1);
    end
  assign quot  = negq_q ? -q_q : q_q;
  assign rem   = negr_q ? -r_q : r_q;
  assign valid = valid_q;
endmodule

// File: rtl/exe_muldiv_hilo.sv
// exe_muldiv_hilo: multi-cycle mul/div engine with HI/LO for the EXE stage.
// Define MULDIV_ACCUM_EN to make MADD(U)/MSUB(U) accumulate into {hi,lo}.
module exe_muldiv_hilo
  import cpu_defines_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + MUL_LAT);
  MulDivStateType state_q, state_d;
  MulDivOpType op_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, lo_q, quot, rem;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, res;
  logic [2*WIDTH-1:0] pipe_q [MUL_LAT];
  logic accept, commit, div_valid, sgn;
  assign sgn    = !op[0];
  assign ext_a  = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a};
  assign ext_b  = {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
  assign prod   = ext_a * ext_b;
  assign accept = resetn & (state_q == IDLE) & start & !flush;
  // product of the accepted operands reaches the last stage exactly in the DONE cycle
  always_ff @(posedge clk) begin
    pipe_q[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
`ifdef MULDIV_ACCUM_EN
  assign acc = (op_q == OP_MADD || op_q == OP_MADDU) ? {hi_q, lo_q} + pipe_q[MUL_LAT-1] :
               (op_q == OP_MSUB || op_q == OP_MSUBU) ? {hi_q, lo_q} - pipe_q[MUL_LAT-1] :
               pipe_q[MUL_LAT-1];
`else
  assign acc = pipe_q[MUL_LAT-1];
`endif
  assign res = op_is_div(op_q) ? {rem, quot} : acc;
  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .resetn(resetn),
    .start (accept & op_is_div(op)),
    .abort (flush),
    .sgn   (sgn),
    .a     (src_a),
    .b     (src_b),
    .quot  (quot),
    .rem   (rem),
    .valid (div_valid)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) op_q <= MulDivOpType'(op);
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = op_is_div(op) ? DIV : (MUL_LAT == 1 ? DONE : MUL);
        cnt_d   = op_is_div(op) ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
      end
      MUL, DIV: begin
        state_d = (cnt_q == CW'(1)) ? DONE : state_q;
        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_comb begin
    stall  = accept | ((state_q == MUL || state_q == DIV) & !flush);
    commit = (state_q == DONE) & !flush & (!op_is_div(op_q) | div_valid);
    done   = commit;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      {hi_q, lo_q} <= res;
    end else begin
      if (hi_wr) hi_q <= wr_data;
      if (lo_wr) lo_q <= wr_data;
    end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
